// File: rtl/fprint_gated_pio_if.sv
// Bus bundle for fprint_gated_pio: the Avalon register port, the task context,
// the comparator release/discard controls and the committed output with its pulses.
interface fprint_gated_pio_if #(
  parameter int DATA_W = 4,
  parameter int TASK_W = 5
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [TASK_W:0]   active_task;
  logic              io_release;
  logic [TASK_W-1:0] io_key;
  logic              io_discard;
  logic [DATA_W-1:0] out_port;
  logic              release_ack;
  logic              release_reject;

  modport master (
    output address, chipselect, write_n, writedata, active_task,
           io_release, io_key, io_discard,
    input  readdata, out_port, release_ack, release_reject
  );

  modport slave (
    input  address, chipselect, write_n, writedata, active_task,
           io_release, io_key, io_discard,
    output readdata, out_port, release_ack, release_reject
  );
endinterface

// File: rtl/fprint_gated_pio.sv
// Gated parallel output: software stages task-tagged values in a FIFO, and only a
// release whose key matches the head task id may commit the head value to out_port.
module fprint_gated_pio #(
  parameter int                DATA_W    = 4,
  parameter int                DEPTH     = 4,
  parameter int                TASK_W    = 5,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  fprint_gated_pio_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TASK_W-1:0] id_mem   [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              rej;
  logic [DATA_W-1:0] out_q;
  logic              ack_q;
  logic              rej_q;

  logic              bus_wr;
  logic              stage_wr;
  logic              status_wr;
  logic              head_hit;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              rej_set;
  logic [31:0]       rd_data;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

  assign bus_wr    = bus.chipselect & ~bus.write_n;
  assign stage_wr  = bus_wr & (bus.address == 2'd0) & bus.active_task[TASK_W];
  assign status_wr = bus_wr & (bus.address == 2'd1);
  assign head_hit  = ~empty & (id_mem[rd_ptr] == bus.io_key);

  // Discard overrides everything: no commit, no refusal, and the staged write is lost.
  assign pop       = bus.io_release & head_hit & ~bus.io_discard;
  assign rej_set   = bus.io_release & ~head_hit & ~bus.io_discard;
  assign push      = stage_wr & ~bus.io_discard & (~full | pop);
  assign ovf_set   = stage_wr & ~bus.io_discard & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.io_discard) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.writedata[DATA_W-1:0];
      id_mem[wr_ptr]   <= bus.active_task[TASK_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= RESET_VAL;
      ack_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      ack_q <= pop;
      rej_q <= rej_set;
      if (pop)
        out_q <= data_mem[rd_ptr];
    end
  end

  // Sticky flags: a set in the same cycle as a write-1-to-clear keeps the flag up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
      rej <= 1'b0;
    end else begin
      if (ovf_set)
        ovf <= 1'b1;
      else if (status_wr && bus.writedata[3])
        ovf <= 1'b0;
      if (rej_set)
        rej <= 1'b1;
      else if (status_wr && bus.writedata[2])
        rej <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.address)
      2'd0: rd_data[DATA_W-1:0] = out_q;
      2'd1: begin
        rd_data[12:8] = 5'(count);
        rd_data[3]    = ovf;
        rd_data[2]    = rej;
        rd_data[1]    = full;
        rd_data[0]    = empty;
      end
      2'd2: begin
        if (!empty) begin
          rd_data[TASK_W+15:16] = id_mem[rd_ptr];
          rd_data[DATA_W-1:0]   = data_mem[rd_ptr];
        end
      end
      default: rd_data = '0;
    endcase
  end

  assign bus.readdata       = rd_data;
  assign bus.out_port       = out_q;
  assign bus.release_ack    = ack_q;
  assign bus.release_reject = rej_q;

endmodule

// File: tb/tb_fprint_gated_pio.sv
// Self-checking bench for fprint_gated_pio: directed scenarios plus a randomized run
// against a queue-based reference model of the staging/release rules.
`timescale 1ns/1ps
module tb_fprint_gated_pio;
  localparam int                DATA_W    = 4;
  localparam int                DEPTH     = 4;
  localparam int                TASK_W    = 5;
  localparam logic [DATA_W-1:0] RESET_VAL = 4'h6;

  typedef struct packed {
    logic [TASK_W-1:0] id;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic clk;
  logic reset_n;

  fprint_gated_pio_if #(.DATA_W(DATA_W), .TASK_W(TASK_W)) bus ();

  fprint_gated_pio #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .TASK_W(TASK_W), .RESET_VAL(RESET_VAL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // reference model state
  entry_t            mq[$];
  logic [DATA_W-1:0] m_out;
  bit                m_ovf, m_rej, m_ack, m_rjp;

  int tests = 0;
  int fails = 0;

  task automatic idle_inputs();
    bus.chipselect  = 1'b0;
    bus.write_n     = 1'b1;
    bus.address     = 2'd0;
    bus.writedata   = '0;
    bus.active_task = '0;
    bus.io_release  = 1'b0;
    bus.io_key      = '0;
    bus.io_discard  = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = RESET_VAL;
    m_ovf = 0;
    m_rej = 0;
    m_ack = 0;
    m_rjp = 0;
  endtask

  // Drive one clock of stimulus and advance the model by the same cycle.
  task automatic step(input bit wr, input logic [1:0] addr, input logic [31:0] wdata,
                      input bit tv, input logic [TASK_W-1:0] tid,
                      input bit rel, input logic [TASK_W-1:0] key, input bit disc);
    bit stage, ovf_s, rej_s;
    bus.chipselect  = wr;
    bus.write_n     = !wr;
    bus.address     = addr;
    bus.writedata   = wdata;
    bus.active_task = {tv, tid};
    bus.io_release  = rel;
    bus.io_key      = key;
    bus.io_discard  = disc;
    stage = wr && addr == 2'd0 && tv;
    ovf_s = 0;
    rej_s = 0;
    m_ack = 0;
    m_rjp = 0;
    if (disc) begin
      mq.delete();
    end else begin
      if (rel) begin
        if (mq.size() > 0 && mq[0].id == key) begin
          m_ack = 1;
          m_out = mq[0].data;
          mq.delete(0);
        end else begin
          m_rjp = 1;
          rej_s = 1;
        end
      end
      if (stage) begin
        if (mq.size() < DEPTH) mq.push_back('{id: tid, data: wdata[DATA_W-1:0]});
        else ovf_s = 1;
      end
    end
    if (wr && addr == 2'd1) begin
      if (wdata[3]) m_ovf = 0;
      if (wdata[2]) m_rej = 0;
    end
    if (ovf_s) m_ovf = 1;
    if (rej_s) m_rej = 1;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    #1;
    v = bus.readdata;
    bus.chipselect = 1'b0;
    bus.address    = 2'd0;
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[DATA_W-1:0] = m_out;
      2'd1: begin
        r[12:8] = 5'(mq.size());
        r[3]    = m_ovf;
        r[2]    = m_rej;
        r[1]    = (mq.size() == DEPTH);
        r[0]    = (mq.size() == 0);
      end
      2'd2: if (mq.size() > 0) begin
        r[TASK_W+15:16] = mq[0].id;
        r[DATA_W-1:0]   = mq[0].data;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    idle_inputs();
    reset_n = 1'b0;
    #25;
    tests++;
    if (bus.out_port !== RESET_VAL) begin
      fails++; $display("FAIL reset_out_during: got %h expected %h", bus.out_port, RESET_VAL);
    end
    #10 reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rd(2'd1, v);
    tests++;
    if (v !== 32'h1) begin
      fails++; $display("FAIL reset_status: got %h expected %h", v, 32'h1);
    end
    tests++;
    if (bus.release_ack !== 1'b0 || bus.release_reject !== 1'b0) begin
      fails++; $display("FAIL reset_pulses: got %b%b expected 00", bus.release_ack, bus.release_reject);
    end
  endtask

  task automatic test_release_match();
    logic [31:0] v;
    step(1, 2'd0, 32'hA, 1, 5'd3, 0, '0, 0);
    rd(2'd1, v);
    tests++;
    if (v !== 32'h100) begin
      fails++; $display("FAIL match_staged_status: got %h expected %h", v, 32'h100);
    end
    step(0, 2'd0, '0, 0, '0, 1, 5'd3, 0);
    tests++;
    if (bus.out_port !== 4'hA || bus.release_ack !== 1'b1 || bus.release_reject !== 1'b0) begin
      fails++; $display("FAIL match_commit: got out=%h ack=%b rej=%b expected out=a ack=1 rej=0",
                        bus.out_port, bus.release_ack, bus.release_reject);
    end
    rd(2'd1, v);
    tests++;
    if (v !== 32'h1) begin
      fails++; $display("FAIL match_status: got %h expected %h", v, 32'h1);
    end
    step(0, 2'd0, '0, 0, '0, 0, '0, 0);
    tests++;
    if (bus.release_ack !== 1'b0) begin
      fails++; $display("FAIL match_ack_pulse: got %b expected 0", bus.release_ack);
    end
  endtask

  task automatic test_reject();
    logic [31:0] v;
    step(1, 2'd0, 32'h5, 1, 5'd2, 0, '0, 0);
    step(0, 2'd0, '0, 0, '0, 1, 5'd7, 0);
    tests++;
    if (bus.release_reject !== 1'b1 || bus.release_ack !== 1'b0 || bus.out_port !== 4'hA) begin
      fails++; $display("FAIL reject_pulse: got rej=%b ack=%b out=%h expected rej=1 ack=0 out=a",
                        bus.release_reject, bus.release_ack, bus.out_port);
    end
    rd(2'd1, v);
    tests++;
    if (v !== 32'h104) begin
      fails++; $display("FAIL reject_status: got %h expected %h", v, 32'h104);
    end
    step(1, 2'd1, 32'h4, 0, '0, 0, '0, 0);
    rd(2'd1, v);
    tests++;
    if (v !== 32'h100 || bus.release_reject !== 1'b0) begin
      fails++; $display("FAIL reject_clear: got %h rej=%b expected %h rej=0", v, bus.release_reject, 32'h100);
    end
    step(0, 2'd0, '0, 0, '0, 0, '0, 1);
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    for (int i = 0; i < 5; i++)
      step(1, 2'd0, 32'(i + 1), 1, 5'(10 + i), 0, '0, 0);
    rd(2'd1, v);
    tests++;
    if (v !== 32'h40A) begin
      fails++; $display("FAIL ovf_status: got %h expected %h", v, 32'h40A);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 2'd0, '0, 0, '0, 1, 5'(10 + i), 0);
      tests++;
      if (bus.out_port !== 4'(i + 1) || bus.release_ack !== 1'b1) begin
        fails++; $display("FAIL ovf_drain%0d: got out=%h ack=%b expected out=%h ack=1",
                          i, bus.out_port, bus.release_ack, 4'(i + 1));
      end
    end
    rd(2'd1, v);
    tests++;
    if (v !== 32'h9) begin
      fails++; $display("FAIL ovf_after_drain: got %h expected %h", v, 32'h9);
    end
    step(1, 2'd1, 32'h8, 0, '0, 0, '0, 0);
    rd(2'd1, v);
    tests++;
    if (v !== 32'h1) begin
      fails++; $display("FAIL ovf_clear: got %h expected %h", v, 32'h1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 4; i++)
      step(1, 2'd0, 32'(8 + i), 1, 5'(i + 1), 0, '0, 0);
    step(1, 2'd0, 32'hF, 1, 5'd9, 1, 5'd1, 0);
    tests++;
    if (bus.out_port !== 4'h8 || bus.release_ack !== 1'b1) begin
      fails++; $display("FAIL b2b_commit: got out=%h ack=%b expected out=8 ack=1", bus.out_port, bus.release_ack);
    end
    rd(2'd1, v);
    tests++;
    if (v !== 32'h402) begin
      fails++; $display("FAIL b2b_status: got %h expected %h", v, 32'h402);
    end
    rd(2'd2, v);
    tests++;
    if (v !== 32'h0002_0009) begin
      fails++; $display("FAIL b2b_head: got %h expected %h", v, 32'h0002_0009);
    end
    step(0, 2'd0, '0, 0, '0, 0, '0, 1);
  endtask

  task automatic test_discard();
    logic [31:0] v;
    step(1, 2'd0, 32'h3, 1, 5'd4, 0, '0, 0);
    step(1, 2'd0, 32'h7, 1, 5'd5, 0, '0, 0);
    step(1, 2'd0, 32'hC, 1, 5'd6, 1, 5'd4, 1);
    tests++;
    if (bus.release_ack !== 1'b0 || bus.release_reject !== 1'b0 || bus.out_port !== 4'h8) begin
      fails++; $display("FAIL discard_outputs: got ack=%b rej=%b out=%h expected ack=0 rej=0 out=8",
                        bus.release_ack, bus.release_reject, bus.out_port);
    end
    rd(2'd1, v);
    tests++;
    if (v !== 32'h1) begin
      fails++; $display("FAIL discard_status: got %h expected %h", v, 32'h1);
    end
  endtask

  task automatic test_invalid_and_reset();
    logic [31:0] v;
    step(1, 2'd0, 32'h2, 1, 5'd1, 0, '0, 0);
    step(1, 2'd0, 32'h9, 0, 5'd1, 0, '0, 0);
    step(1, 2'd2, 32'hFFFF_FFFF, 1, 5'd1, 0, '0, 0);
    step(1, 2'd3, 32'hFFFF_FFFF, 1, 5'd1, 0, '0, 0);
    rd(2'd1, v);
    tests++;
    if (v !== 32'h100 || bus.out_port !== 4'h8) begin
      fails++; $display("FAIL invalid_write: got %h out=%h expected %h out=8", v, bus.out_port, 32'h100);
    end
    rd(2'd3, v);
    tests++;
    if (v !== 32'h0) begin
      fails++; $display("FAIL addr3_read: got %h expected 0", v);
    end
    step(1, 2'd0, 32'h4, 1, 5'd1, 0, '0, 0);
    #3 reset_n = 1'b0;
    #1;
    rd(2'd1, v);
    tests++;
    if (bus.out_port !== RESET_VAL || v !== 32'h1) begin
      fails++; $display("FAIL midreset: got out=%h status=%h expected out=%h status=1", bus.out_port, v, RESET_VAL);
    end
    #27 reset_n = 1'b1;
    model_reset();
    step(0, 2'd0, '0, 0, '0, 0, '0, 0);
    tests++;
    if (bus.release_ack !== 1'b0 || bus.release_reject !== 1'b0 || bus.out_port !== RESET_VAL) begin
      fails++; $display("FAIL post_reset: got ack=%b rej=%b out=%h expected 0 0 %h",
                        bus.release_ack, bus.release_reject, bus.out_port, RESET_VAL);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    bit wr, tv, rel, disc;
    logic [1:0] addr;
    logic [TASK_W-1:0] tid, key;
    for (int n = 0; n < 400; n++) begin
      wr   = ($urandom_range(0, 1) == 1);
      addr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      tv   = ($urandom_range(0, 3) != 0);
      tid  = TASK_W'($urandom_range(0, 3));
      rel  = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) key = mq[0].id;
      else key = TASK_W'($urandom_range(0, 3));
      disc = ($urandom_range(0, 15) == 0);
      step(wr, addr, $urandom, tv, tid, rel, key, disc);
      tests++;
      if (bus.out_port !== m_out || bus.release_ack !== m_ack || bus.release_reject !== m_rjp) begin
        fails++; $display("FAIL rnd_outputs[%0d]: got out=%h ack=%b rej=%b expected out=%h ack=%b rej=%b",
                          n, bus.out_port, bus.release_ack, bus.release_reject, m_out, m_ack, m_rjp);
      end
      for (int a = 0; a < 4; a++) begin
        rd(2'(a), v);
        tests++;
        if (v !== m_reg(2'(a))) begin
          fails++; $display("FAIL rnd_reg%0d[%0d]: got %h expected %h", a, n, v, m_reg(2'(a)));
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    test_reset();
    test_release_match();
    test_reject();
    test_overflow();
    test_back_to_back();
    test_discard();
    test_invalid_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
